ll_cmd_scheduler: RTL and testbench
===================================

// Module: ll_cmd_scheduler
// PURPOSE
//  Shares one linked-list engine (linked_list_top) between N_REQ requesters with round-robin arbitration.
//  Keeps exactly one command in flight and returns the engine result to the requester that issued it.
//  Sequences the data-RAM clear after reset and on request, and blocks commands while the clear runs.
//  Detects a lost result with a watchdog. Sits between the lock/hash clients and linked_list_top.
// PARAMETERS
//  N_REQ     4     number of requesters (2..8)
//  KEY_W     32    width of ll_cmd_if_key (equals LL_KEY_WIDTH)
//  PTR_W     10    width of the head pointer (equals LL_HEAD_PTR_WIDTH)
//  TIMEOUT   1024  cycles in WAIT_RES before the watchdog fires (>=4)
// PORTS
//  clk_i              in   1            clock
//  rst_i              in   1            reset, synchronous, active-high
//  req_valid_i        in   N_REQ        per-requester command valid
//  req_ready_o        out  N_REQ        per-requester accept, one-hot pulse
//  req_key_i          in   N_REQ*KEY_W  keys, requester i at [i*KEY_W +: KEY_W]
//  req_opcode_i       in   N_REQ*2      opcodes (LL_OP_INSERT/DELETE/DEQ)
//  req_head_ptr_i     in   N_REQ*PTR_W  head pointers
//  req_head_ptr_val_i in   N_REQ        head pointer valid
//  res_valid_o        out  N_REQ        per-requester result valid
//  res_ready_i        in   N_REQ        per-requester result ready
//  res_key_o          out  KEY_W        result key, shared by all requesters
//  res_opcode_o       out  2            result opcode, shared
//  res_rescode_o      out  3            result code, shared
//  res_chain_state_o  out  3            chain state, shared
//  ll_cmd_valid_o     out  1            to engine: command valid
//  ll_cmd_ready_i     in   1            from engine: command ready
//  ll_cmd_key_o / ll_cmd_opcode_o / ll_cmd_head_ptr_o / ll_cmd_head_ptr_val_o  out  KEY_W/2/PTR_W/1  registered command
//  ll_res_valid_i     in   1            from engine: result valid
//  ll_res_ready_o     out  1            to engine: result ready
//  ll_res_key_i / ll_res_opcode_i / ll_res_rescode_i / ll_res_chain_state_i  in  KEY_W/2/3/3  engine result
//  clear_req_i        in   1            request a RAM clear
//  clear_ram_run_o    out  1            to engine: clear start pulse
//  clear_ram_done_i   in   1            from engine: clear finished
//  busy_o             out  1            high in every state except IDLE
//  timeout_o          out  1            one-cycle watchdog pulse
// BEHAVIOUR
//  Reset state and reset values
//  - rst_i puts the FSM in CLR_RUN and sets rr_ptr=0 and gnt_id=0.
//  - Every output is 0 during reset; command registers clear to 0.
//  FSM transitions
//  - CLR_RUN: clear_ram_run_o=1 for exactly 1 cycle, then -> CLR_WAIT.
//  - CLR_WAIT: wait for clear_ram_done_i=1, then -> IDLE. No timeout applies.
//  - IDLE: clear_req_i has priority over commands -> CLR_RUN.
//  - IDLE: else if any req_valid_i, grant the first valid index at or after rr_ptr (modulo N_REQ).
//    In the same cycle: req_ready_o[g]=1, latch the command fields, gnt_id<=g, rr_ptr<=(g+1)%N_REQ, -> ISSUE.
//  - ISSUE: ll_cmd_valid_o=1 with the registered fields held stable; on ll_cmd_ready_i -> WAIT_RES.
//  - WAIT_RES: route the result combinationally.
//    res_valid_o[gnt_id]=ll_res_valid_i; all other bits of res_valid_o are 0.
//    ll_res_ready_o=res_ready_i[gnt_id]; the res_* data outputs pass through from ll_res_*.
//    On the ll_res handshake -> IDLE.
//  Watchdog
//  - wd_cnt counts WAIT_RES cycles and clears on entry to WAIT_RES.
//  - When wd_cnt==TIMEOUT-1 with no result: timeout_o=1 for 1 cycle, ll_res_ready_o=1 to drop any late result, -> CLR_RUN.
//  Latency and ordering
//  - Acceptance in cycle T gives ll_cmd_valid_o in cycle T+1. There is no bubble after a result other than one IDLE cycle.
//  - At most one command is outstanding, so results are in order by construction.
//  Simultaneous and boundary events
//  - clear_req_i is ignored outside IDLE; hold it until busy_o falls.
//  - A requester that drops req_valid_i before its grant is simply skipped.
//  - With a single valid requester, that requester is granted on every IDLE.
//  - rr_ptr wraps from N_REQ-1 to 0.
//  - If an unknown opcode is accepted, the engine acks it with no result, the watchdog fires, and the clear path recovers.
//  - rst_i asserted mid-transaction aborts the transaction at once; no pending grant or result survives.
//  - After reset, clear_ram_run_o rises in the first cycle that rst_i is low.
// TESTING
//  1 Reset, then clear_ram_done_i 5 cycles after clear_ram_run_o
//    -> clear_ram_run_o is a single pulse, busy_o=1 until done, IDLE at done+1.
//  2 req_valid_i=4'b1111 held, engine acks each command and returns results immediately
//    -> grants 0,1,2,3,0 in order, each res_valid_o one-hot on the matching bit.
//  3 Requester 2 INSERT key=0xDEAD, ll_cmd_ready_i low 3 cycles
//    -> ll_cmd_valid_o stays high with key held at 0xDEAD for 4 cycles, req_ready_o[2] pulses once.
//  4 Result arrives while res_ready_i[1]=0 for 2 cycles
//    -> ll_res_ready_o=0 and the result is held; handshake completes on cycle 3.
//  5 TIMEOUT=8, engine never answers
//    -> timeout_o pulse 8 cycles after entering WAIT_RES, then clear_ram_run_o the next cycle.
//  6 clear_req_i and req_valid_i[0] both asserted in IDLE
//    -> clear sequence runs first; requester 0 is granted in the first IDLE after clear_ram_done_i.

Source files
------------

// File: rtl/ll_cmd_scheduler_if.sv
// Requester-side and engine-side signal bundle for ll_cmd_scheduler.
// The scheduler connects through the slave modport; the environment through master.
interface ll_cmd_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int KEY_W = 32,
    parameter int PTR_W = 10
);
    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic [N_REQ*KEY_W-1:0] req_key_i;
    logic [N_REQ*2-1:0]     req_opcode_i;
    logic [N_REQ*PTR_W-1:0] req_head_ptr_i;
    logic [N_REQ-1:0]       req_head_ptr_val_i;
    logic [N_REQ-1:0]       res_valid_o;
    logic [N_REQ-1:0]       res_ready_i;
    logic [KEY_W-1:0]       res_key_o;
    logic [1:0]             res_opcode_o;
    logic [2:0]             res_rescode_o;
    logic [2:0]             res_chain_state_o;
    logic                   ll_cmd_valid_o;
    logic                   ll_cmd_ready_i;
    logic [KEY_W-1:0]       ll_cmd_key_o;
    logic [1:0]             ll_cmd_opcode_o;
    logic [PTR_W-1:0]       ll_cmd_head_ptr_o;
    logic                   ll_cmd_head_ptr_val_o;
    logic                   ll_res_valid_i;
    logic                   ll_res_ready_o;
    logic [KEY_W-1:0]       ll_res_key_i;
    logic [1:0]             ll_res_opcode_i;
    logic [2:0]             ll_res_rescode_i;
    logic [2:0]             ll_res_chain_state_i;
    logic                   clear_req_i;
    logic                   clear_ram_run_o;
    logic                   clear_ram_done_i;
    logic                   busy_o;
    logic                   timeout_o;

    modport slave (
        input  req_valid_i, req_key_i, req_opcode_i,
        input  req_head_ptr_i, req_head_ptr_val_i, res_ready_i,
        input  ll_cmd_ready_i, ll_res_valid_i, ll_res_key_i,
        input  ll_res_opcode_i, ll_res_rescode_i, ll_res_chain_state_i,
        input  clear_req_i, clear_ram_done_i,
        output req_ready_o, res_valid_o, res_key_o, res_opcode_o,
        output res_rescode_o, res_chain_state_o,
        output ll_cmd_valid_o, ll_cmd_key_o, ll_cmd_opcode_o,
        output ll_cmd_head_ptr_o, ll_cmd_head_ptr_val_o,
        output ll_res_ready_o, clear_ram_run_o, busy_o, timeout_o
    );

    modport master (
        output req_valid_i, req_key_i, req_opcode_i,
        output req_head_ptr_i, req_head_ptr_val_i, res_ready_i,
        output ll_cmd_ready_i, ll_res_valid_i, ll_res_key_i,
        output ll_res_opcode_i, ll_res_rescode_i, ll_res_chain_state_i,
        output clear_req_i, clear_ram_done_i,
        input  req_ready_o, res_valid_o, res_key_o, res_opcode_o,
        input  res_rescode_o, res_chain_state_o,
        input  ll_cmd_valid_o, ll_cmd_key_o, ll_cmd_opcode_o,
        input  ll_cmd_head_ptr_o, ll_cmd_head_ptr_val_o,
        input  ll_res_ready_o, clear_ram_run_o, busy_o, timeout_o
    );
endinterface

// File: rtl/ll_cmd_scheduler.sv
// Round-robin front end sharing one linked-list engine between N_REQ clients.
// One command in flight, RAM clear sequencing, and a result watchdog.
module ll_cmd_scheduler #(
    parameter int N_REQ   = 4,
    parameter int KEY_W   = 32,
    parameter int PTR_W   = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    ll_cmd_scheduler_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        CLR_RUN,
        CLR_WAIT,
        IDLE,
        ISSUE,
        WAIT_RES
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_id;
    logic [WD_W-1:0]  wd_cnt;
    logic [KEY_W-1:0] cmd_key;
    logic [1:0]       cmd_opcode;
    logic [PTR_W-1:0] cmd_head_ptr;
    logic             cmd_head_ptr_val;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   scan_idx;
    logic [IDX_W-1:0] next_rr;
    logic             in_idle;
    logic             in_wait;
    logic             accept;
    logic             res_hs;
    logic             wd_fire;
    logic             res_ready_int;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] res_valid;

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(N_REQ))
                scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
            if (!pick_found && bus.req_valid_i[scan_idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign next_rr = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;

    // Outputs are decoded from registered state and held low while in reset.
    assign in_idle = (state == IDLE) && !rst_i;
    assign in_wait = (state == WAIT_RES) && !rst_i;
    assign accept  = in_idle && !bus.clear_req_i && pick_found;

    assign res_hs  = bus.ll_res_valid_i && bus.res_ready_i[gnt_id];
    assign wd_fire = in_wait && (wd_cnt == WD_W'(TIMEOUT-1)) && !res_hs;
    assign res_ready_int = in_wait && (bus.res_ready_i[gnt_id] || wd_fire);

    // One-hot accept pulse and result-valid steering toward the granted client.
    always_comb begin
        req_ready = '0;
        res_valid = '0;
        if (accept)
            req_ready[pick_idx] = 1'b1;
        if (in_wait)
            res_valid[gnt_id] = bus.ll_res_valid_i;
    end

    assign bus.req_ready_o       = req_ready;
    assign bus.res_valid_o       = res_valid;
    assign bus.res_key_o         = in_wait ? bus.ll_res_key_i : '0;
    assign bus.res_opcode_o      = in_wait ? bus.ll_res_opcode_i : '0;
    assign bus.res_rescode_o     = in_wait ? bus.ll_res_rescode_i : '0;
    assign bus.res_chain_state_o = in_wait ? bus.ll_res_chain_state_i : '0;
    assign bus.ll_res_ready_o    = res_ready_int;

    assign bus.ll_cmd_valid_o        = (state == ISSUE) && !rst_i;
    assign bus.ll_cmd_key_o          = cmd_key;
    assign bus.ll_cmd_opcode_o       = cmd_opcode;
    assign bus.ll_cmd_head_ptr_o     = cmd_head_ptr;
    assign bus.ll_cmd_head_ptr_val_o = cmd_head_ptr_val;

    assign bus.clear_ram_run_o = (state == CLR_RUN) && !rst_i;
    assign bus.busy_o          = (state != IDLE) && !rst_i;
    assign bus.timeout_o       = wd_fire;

    // Scheduler FSM: clear sequencing, grant, issue, result wait and watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= CLR_RUN;
            rr_ptr           <= '0;
            gnt_id           <= '0;
            wd_cnt           <= '0;
            cmd_key          <= '0;
            cmd_opcode       <= '0;
            cmd_head_ptr     <= '0;
            cmd_head_ptr_val <= 1'b0;
        end else begin
            unique case (state)
                CLR_RUN: state <= CLR_WAIT;
                CLR_WAIT: begin
                    if (bus.clear_ram_done_i)
                        state <= IDLE;
                end
                IDLE: begin
                    if (bus.clear_req_i) begin
                        state <= CLR_RUN;
                    end else if (pick_found) begin
                        cmd_key          <= bus.req_key_i[pick_idx*KEY_W +: KEY_W];
                        cmd_opcode       <= bus.req_opcode_i[pick_idx*2 +: 2];
                        cmd_head_ptr     <= bus.req_head_ptr_i[pick_idx*PTR_W +: PTR_W];
                        cmd_head_ptr_val <= bus.req_head_ptr_val_i[pick_idx];
                        gnt_id           <= pick_idx;
                        rr_ptr           <= next_rr;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.ll_cmd_ready_i) begin
                        wd_cnt <= '0;
                        state  <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (wd_fire)
                        state <= CLR_RUN;
                    else if (bus.ll_res_valid_i && res_ready_int)
                        state <= IDLE;
                    else
                        wd_cnt <= wd_cnt + 1'b1;
                end
                default: state <= CLR_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_ll_cmd_scheduler.sv
// Bench for ll_cmd_scheduler: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_ll_cmd_scheduler;
    localparam int NR = 4;
    localparam int KW = 32;
    localparam int PW = 10;
    localparam int TO = 8;
    localparam logic [1:0] OP_INSERT = 2'd0;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    int   m_rr;

    logic [KW-1:0] f_key [NR];
    logic [1:0]    f_op  [NR];
    logic [PW-1:0] f_ptr [NR];
    logic          f_pv  [NR];

    ll_cmd_scheduler_if #(.N_REQ(NR), .KEY_W(KW), .PTR_W(PW)) bus ();

    ll_cmd_scheduler #(
        .N_REQ(NR), .KEY_W(KW), .PTR_W(PW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbitration: first set bit at or after ptr, modulo NR.
    function automatic int pick(input logic [NR-1:0] mask, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic quiet();
        bus.req_valid_i          = '0;
        bus.req_key_i            = '0;
        bus.req_opcode_i         = '0;
        bus.req_head_ptr_i       = '0;
        bus.req_head_ptr_val_i   = '0;
        bus.res_ready_i          = '0;
        bus.ll_cmd_ready_i       = 1'b0;
        bus.ll_res_valid_i       = 1'b0;
        bus.ll_res_key_i         = '0;
        bus.ll_res_opcode_i      = '0;
        bus.ll_res_rescode_i     = '0;
        bus.ll_res_chain_state_i = '0;
        bus.clear_req_i          = 1'b0;
        bus.clear_ram_done_i     = 1'b0;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < NR; i++) begin
            bus.req_key_i[i*KW +: KW]      = f_key[i];
            bus.req_opcode_i[i*2 +: 2]     = f_op[i];
            bus.req_head_ptr_i[i*PW +: PW] = f_ptr[i];
            bus.req_head_ptr_val_i[i]      = f_pv[i];
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            f_key[i] = $urandom;
            f_op[i]  = 2'($urandom_range(0, 2));
            f_ptr[i] = PW'($urandom);
            f_pv[i]  = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        int runs;
        int busy_bad;
        logic run0;
        rst = 1'b1;
        quiet();
        bus.req_valid_i    = '1;
        bus.clear_req_i    = 1'b1;
        bus.ll_res_valid_i = 1'b1;
        bus.ll_cmd_ready_i = 1'b1;
        bus.res_ready_i    = '1;
        repeat (2) @(negedge clk);
        #1;
        n_run++;
        if ({bus.req_ready_o, bus.res_valid_o, bus.ll_cmd_valid_o,
             bus.ll_res_ready_o, bus.clear_ram_run_o, bus.busy_o,
             bus.timeout_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b cv=%b lr=%b run=%b busy=%b to=%b want all 0",
                     bus.req_ready_o, bus.res_valid_o, bus.ll_cmd_valid_o,
                     bus.ll_res_ready_o, bus.clear_ram_run_o, bus.busy_o, bus.timeout_o);
        end
        n_run++;
        if ({bus.ll_cmd_key_o, bus.ll_cmd_opcode_o, bus.ll_cmd_head_ptr_o,
             bus.ll_cmd_head_ptr_val_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd_regs: got key=%0h op=%0h ptr=%0h pv=%b want 0",
                     bus.ll_cmd_key_o, bus.ll_cmd_opcode_o,
                     bus.ll_cmd_head_ptr_o, bus.ll_cmd_head_ptr_val_o);
        end
        quiet();
        @(negedge clk);
        rst      = 1'b0;
        runs     = 0;
        busy_bad = 0;
        run0     = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            bus.clear_ram_done_i = (c == 5);
            #1;
            if (bus.clear_ram_run_o === 1'b1) runs++;
            if (c == 0) run0 = bus.clear_ram_run_o;
            if (c <= 5 && bus.busy_o !== 1'b1) busy_bad++;
        end
        n_run++;
        if (run0 !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_run_first: got %b want 1", run0);
        end
        n_run++;
        if (runs != 1) begin
            n_fail++;
            $display("FAIL clr_run_pulse: got %0d pulses want 1", runs);
        end
        n_run++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL clr_busy: got %0d low cycles want 0", busy_bad);
        end
        n_run++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_idle_after_done: got busy=%b want 0", bus.busy_o);
        end
        m_rr = 0;
        @(negedge clk);
        quiet();
    endtask

    task automatic test_round_robin();
        int g;
        @(negedge clk);
        quiet();
        for (int i = 0; i < NR; i++) begin
            f_key[i] = 32'h1000 + i;
            f_op[i]  = 2'(i % 3);
            f_ptr[i] = PW'(i * 7);
            f_pv[i]  = 1'b1;
        end
        drive_fields();
        bus.req_valid_i    = '1;
        bus.ll_cmd_ready_i = 1'b1;
        bus.ll_res_valid_i = 1'b1;
        bus.ll_res_key_i   = 32'hCAFE0000;
        bus.res_ready_i    = '1;
        for (int t = 0; t < 5; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            g = pick(4'b1111, m_rr);
            m_rr = (g + 1) % NR;
            n_run++;
            if (bus.req_ready_o !== (4'b0001 << g)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", t, bus.req_ready_o, 4'b0001 << g);
            end
            @(negedge clk);
            #1;
            n_run++;
            if (bus.ll_cmd_valid_o !== 1'b1 || bus.ll_cmd_key_o !== f_key[g]) begin
                n_fail++;
                $display("FAIL rr_cmd[%0d]: got v=%b key=%0h want v=1 key=%0h",
                         t, bus.ll_cmd_valid_o, bus.ll_cmd_key_o, f_key[g]);
            end
            @(negedge clk);
            #1;
            n_run++;
            if (bus.res_valid_o !== (4'b0001 << g) || bus.ll_res_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_res[%0d]: got rv=%b lr=%b want rv=%b lr=1",
                         t, bus.res_valid_o, bus.ll_res_ready_o, 4'b0001 << g);
            end
        end
        bus.req_valid_i = '0;
        @(negedge clk);
        quiet();
    endtask

    task automatic test_cmd_hold();
        int g;
        int held;
        int pulses;
        @(negedge clk);
        quiet();
        rand_fields();
        f_key[2] = 32'hDEAD;
        f_op[2]  = OP_INSERT;
        drive_fields();
        bus.req_valid_i = 4'b0100;
        #1;
        g = pick(4'b0100, m_rr);
        m_rr = (g + 1) % NR;
        n_run++;
        if (bus.req_ready_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL hold_grant: got %b want %b", bus.req_ready_o, 4'b0001 << g);
        end
        pulses = (bus.req_ready_o[2] === 1'b1) ? 1 : 0;
        held   = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.req_valid_i    = '0;
            bus.req_key_i      = {$urandom, $urandom, $urandom, $urandom};
            bus.ll_cmd_ready_i = (c == 3);
            #1;
            if (bus.ll_cmd_valid_o === 1'b1 && bus.ll_cmd_key_o === 32'hDEAD &&
                bus.ll_cmd_opcode_o === OP_INSERT) held++;
            if (bus.req_ready_o[2] === 1'b1) pulses++;
        end
        n_run++;
        if (held != 4) begin
            n_fail++;
            $display("FAIL hold_cmd: got %0d stable cycles want 4", held);
        end
        n_run++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL hold_ready_once: got %0d pulses want 1", pulses);
        end
        @(negedge clk);
        bus.ll_cmd_ready_i   = 1'b0;
        bus.ll_res_valid_i   = 1'b1;
        bus.ll_res_key_i     = 32'h0BADF00D;
        bus.ll_res_rescode_i = 3'd5;
        bus.res_ready_i      = 4'b0100;
        #1;
        n_run++;
        if ({bus.res_valid_o, bus.res_key_o, bus.res_rescode_o} !==
            {4'b0100, 32'h0BADF00D, 3'd5}) begin
            n_fail++;
            $display("FAIL hold_res_route: got rv=%b key=%0h rc=%0d want rv=0100 key=badf00d rc=5",
                     bus.res_valid_o, bus.res_key_o, bus.res_rescode_o);
        end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_res_stall();
        int g;
        @(negedge clk);
        quiet();
        bus.req_valid_i = 4'b0010;
        #1;
        g = pick(4'b0010, m_rr);
        m_rr = (g + 1) % NR;
        n_run++;
        if (bus.req_ready_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL stall_grant: got %b want %b", bus.req_ready_o, 4'b0001 << g);
        end
        @(negedge clk);
        bus.req_valid_i    = '0;
        bus.ll_cmd_ready_i = 1'b1;
        @(negedge clk);
        bus.ll_cmd_ready_i = 1'b0;
        bus.ll_res_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            bus.res_ready_i = (c < 2) ? 4'b1101 : 4'b1111;
            #1;
            n_run++;
            if (bus.ll_res_ready_o !== (c == 2) || bus.res_valid_o !== 4'b0010) begin
                n_fail++;
                $display("FAIL stall_c%0d: got lr=%b rv=%b want lr=%b rv=0010",
                         c, bus.ll_res_ready_o, bus.res_valid_o, c == 2);
            end
        end
        @(negedge clk);
        quiet();
        #1;
        n_run++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_idle: got busy=%b want 0", bus.busy_o);
        end
    endtask

    task automatic test_watchdog();
        int g;
        int pulses;
        int at;
        logic rdy_fire;
        logic run_next;
        @(negedge clk);
        quiet();
        rand_fields();
        f_op[3] = 2'b11;
        drive_fields();
        bus.req_valid_i = 4'b1000;
        #1;
        g = pick(4'b1000, m_rr);
        m_rr = (g + 1) % NR;
        n_run++;
        if (bus.req_ready_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL wd_grant: got %b want %b", bus.req_ready_o, 4'b0001 << g);
        end
        @(negedge clk);
        bus.req_valid_i    = '0;
        bus.ll_cmd_ready_i = 1'b1;
        pulses   = 0;
        at       = -1;
        rdy_fire = 1'b0;
        run_next = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            bus.ll_cmd_ready_i = 1'b0;
            #1;
            if (bus.timeout_o === 1'b1) begin
                pulses++;
                at = c;
            end
            if (c == TO - 1) rdy_fire = bus.ll_res_ready_o;
            if (c == TO) run_next = bus.clear_ram_run_o;
        end
        n_run++;
        if (pulses != 1 || at != TO - 1) begin
            n_fail++;
            $display("FAIL wd_pulse: got %0d pulses at %0d want 1 at %0d", pulses, at, TO - 1);
        end
        n_run++;
        if (rdy_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_drop_ready: got %b want 1", rdy_fire);
        end
        n_run++;
        if (run_next !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_clear_run: got %b want 1", run_next);
        end
        @(negedge clk);
        bus.clear_ram_done_i = 1'b1;
        @(negedge clk);
        bus.clear_ram_done_i = 1'b0;
        #1;
        n_run++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_recovered: got busy=%b want 0", bus.busy_o);
        end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_clear_priority();
        int g;
        @(negedge clk);
        quiet();
        bus.clear_req_i = 1'b1;
        bus.req_valid_i = 4'b0001;
        #1;
        n_run++;
        if (bus.req_ready_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL clrp_block: got %b want 0000", bus.req_ready_o);
        end
        @(negedge clk);
        bus.clear_req_i = 1'b0;
        #1;
        n_run++;
        if (bus.clear_ram_run_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clrp_run: got %b want 1", bus.clear_ram_run_o);
        end
        @(negedge clk);
        @(negedge clk);
        bus.clear_ram_done_i = 1'b1;
        @(negedge clk);
        bus.clear_ram_done_i = 1'b0;
        #1;
        g = pick(4'b0001, m_rr);
        m_rr = (g + 1) % NR;
        n_run++;
        if (bus.req_ready_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL clrp_grant: got %b want %b", bus.req_ready_o, 4'b0001 << g);
        end
        @(negedge clk);
        bus.req_valid_i    = '0;
        bus.ll_cmd_ready_i = 1'b1;
        @(negedge clk);
        bus.ll_cmd_ready_i = 1'b0;
        bus.ll_res_valid_i = 1'b1;
        bus.res_ready_i    = '1;
        #1;
        n_run++;
        if (bus.res_valid_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL clrp_res: got %b want %b", bus.res_valid_o, 4'b0001 << g);
        end
        @(negedge clk);
        quiet();
    endtask

    task automatic test_reset_abort();
        int g;
        @(negedge clk);
        quiet();
        bus.req_valid_i = 4'b1100;
        #1;
        g = pick(4'b1100, m_rr);
        m_rr = (g + 1) % NR;
        @(negedge clk);
        bus.req_valid_i    = '0;
        bus.ll_cmd_ready_i = 1'b1;
        @(negedge clk);
        bus.ll_cmd_ready_i = 1'b0;
        bus.ll_res_valid_i = 1'b1;
        bus.res_ready_i    = '1;
        rst = 1'b1;
        #1;
        n_run++;
        if ({bus.res_valid_o, bus.ll_res_ready_o, bus.busy_o, bus.req_ready_o} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rv=%b lr=%b busy=%b rdy=%b want 0",
                     bus.res_valid_o, bus.ll_res_ready_o, bus.busy_o, bus.req_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet();
        m_rr = 0;
        #1;
        n_run++;
        if (bus.clear_ram_run_o !== 1'b1 || bus.ll_cmd_valid_o !== 1'b0 ||
            bus.ll_cmd_key_o !== '0) begin
            n_fail++;
            $display("FAIL abort_restart: got run=%b cv=%b key=%0h want run=1 cv=0 key=0",
                     bus.clear_ram_run_o, bus.ll_cmd_valid_o, bus.ll_cmd_key_o);
        end
        @(negedge clk);
        bus.clear_ram_done_i = 1'b1;
        @(negedge clk);
        bus.clear_ram_done_i = 1'b0;
        bus.req_valid_i      = 4'b1100;
        #1;
        g = pick(4'b1100, m_rr);
        m_rr = (g + 1) % NR;
        n_run++;
        if (bus.req_ready_o !== (4'b0001 << g)) begin
            n_fail++;
            $display("FAIL abort_rr_reset: got %b want %b", bus.req_ready_o, 4'b0001 << g);
        end
        @(negedge clk);
        bus.req_valid_i    = '0;
        bus.ll_cmd_ready_i = 1'b1;
        @(negedge clk);
        bus.ll_cmd_ready_i = 1'b0;
        bus.ll_res_valid_i = 1'b1;
        bus.res_ready_i    = '1;
        @(negedge clk);
        quiet();
    endtask

    task automatic test_random();
        int g;
        int cd;
        int rd;
        int st;
        int bad;
        logic [NR-1:0] mask;
        logic [NR-1:0] rr;
        logic [NR-1:0] exp_rv;
        logic [KW-1:0] rkey;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            quiet();
            mask = NR'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) begin
                bus.clear_req_i = 1'b1;
                bus.req_valid_i = mask;
                #1;
                n_run++;
                if (bus.req_ready_o !== '0) begin
                    n_fail++;
                    $display("FAIL rnd_clr_block[%0d]: got %b want 0000", t, bus.req_ready_o);
                end
                @(negedge clk);
                bus.clear_req_i = 1'b0;
                #1;
                n_run++;
                if (bus.clear_ram_run_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_clr_run[%0d]: got %b want 1", t, bus.clear_ram_run_o);
                end
                repeat ($urandom_range(1, 4)) @(negedge clk);
                bus.clear_ram_done_i = 1'b1;
                @(negedge clk);
                bus.clear_ram_done_i = 1'b0;
                bus.req_valid_i      = '0;
                continue;
            end
            rand_fields();
            drive_fields();
            bus.req_valid_i = mask;
            #1;
            g = pick(mask, m_rr);
            m_rr = (g + 1) % NR;
            n_run++;
            if (bus.req_ready_o !== (4'b0001 << g)) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: got %b want %b mask=%b",
                         t, bus.req_ready_o, 4'b0001 << g, mask);
            end
            cd  = $urandom_range(0, 3);
            bad = 0;
            for (int c = 0; c <= cd; c++) begin
                @(negedge clk);
                bus.req_valid_i    = NR'($urandom);
                bus.req_key_i      = {$urandom, $urandom, $urandom, $urandom};
                bus.req_opcode_i   = 8'($urandom);
                bus.ll_cmd_ready_i = (c == cd);
                #1;
                if (bus.ll_cmd_valid_o !== 1'b1 || bus.ll_cmd_key_o !== f_key[g] ||
                    bus.ll_cmd_opcode_o !== f_op[g] || bus.ll_cmd_head_ptr_o !== f_ptr[g] ||
                    bus.ll_cmd_head_ptr_val_o !== f_pv[g] || bus.req_ready_o !== '0 ||
                    bus.res_valid_o !== '0) bad++;
            end
            n_run++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd_cmd[%0d]: got %0d bad cycles want 0 (key=%0h want %0h)",
                         t, bad, bus.ll_cmd_key_o, f_key[g]);
            end
            rd   = $urandom_range(0, 3);
            st   = $urandom_range(0, 2);
            rkey = $urandom;
            bad  = 0;
            for (int c = 0; c <= rd + st; c++) begin
                @(negedge clk);
                bus.ll_cmd_ready_i = 1'b0;
                bus.req_valid_i    = NR'($urandom);
                bus.ll_res_key_i   = rkey;
                bus.ll_res_valid_i = (c >= rd);
                rr    = NR'($urandom);
                rr[g] = (c == rd + st);
                bus.res_ready_i = rr;
                #1;
                exp_rv = (c >= rd) ? (4'b0001 << g) : 4'b0000;
                if (bus.res_valid_o !== exp_rv || bus.ll_res_ready_o !== (c == rd + st) ||
                    bus.res_key_o !== rkey || bus.timeout_o !== 1'b0) bad++;
            end
            n_run++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rnd_res[%0d]: got %0d bad cycles want 0 (rv=%b)",
                         t, bad, bus.res_valid_o);
            end
        end
        @(negedge clk);
        quiet();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        m_rr   = 0;
        rst    = 1'b1;
        quiet();
        test_reset();
        test_round_robin();
        test_cmd_hold();
        test_res_stall();
        test_watchdog();
        test_clear_priority();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
